// File: rtl/rv32e_rf_wb_arbiter.sv
// Writeback arbiter for the RV32E register-file write port: round-robin grant, registered write, x0/illegal-rd filtering.
// Define RV32E_WB_ARB_FIXED_PRIO_EN to use fixed priority, where the lowest index always wins.
module rv32e_rf_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int CNT_W   = 8
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*5-1:0]    req_rd,
  input  logic [NUM_REQ*32-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    rf_wen,
  output logic [4:0]              rf_rd,
  output logic [31:0]             rf_wdata,
  output logic [CNT_W-1:0]        illegal_cnt,
  output logic                    illegal_flag
);
  // Handshake: requester i's write is taken in a cycle where req_valid[i] & req_ready[i]
  // are both high. req_ready is combinational and at most one-hot. A requester holds
  // valid, rd and data stable until it sees ready.

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] gnt_onehot;
  logic               gnt_found;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   cand_idx;
  int                 cand;
  logic [4:0]         gnt_rd;
  logic [31:0]        gnt_data;

  logic               rf_wen_d, rf_wen_q;
  logic [4:0]         rf_rd_d, rf_rd_q;
  logic [31:0]        rf_wdata_d, rf_wdata_q;
  logic [CNT_W-1:0]   illegal_cnt_d, illegal_cnt_q;
  logic               illegal_flag_d, illegal_flag_q;

`ifndef RV32E_WB_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]   last_gnt_d, last_gnt_q;
`endif

  always_comb begin
    gnt_found  = 1'b0;
    gnt_idx    = '0;
    gnt_onehot = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
`ifdef RV32E_WB_ARB_FIXED_PRIO_EN
      cand = off;
`else
      // Search starts just past the previous winner and wraps around.
      cand = int'(last_gnt_q) + 1 + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
`endif
      cand_idx = IDX_W'(cand);
      if (!gnt_found && req_valid[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
    if (gnt_found && nRST) gnt_onehot[gnt_idx] = 1'b1;

    gnt_rd   = '0;
    gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_onehot[i]) begin
        gnt_rd   = req_rd[i*5 +: 5];
        gnt_data = req_data[i*32 +: 32];
      end
    end
  end

  assign req_ready = gnt_onehot;

  always_comb begin
    rf_wen_d       = 1'b0;
    rf_rd_d        = rf_rd_q;
    rf_wdata_d     = rf_wdata_q;
    illegal_cnt_d  = illegal_cnt_q;
    illegal_flag_d = illegal_flag_q;
`ifndef RV32E_WB_ARB_FIXED_PRIO_EN
    last_gnt_d     = last_gnt_q;
`endif
    if (|gnt_onehot) begin
`ifndef RV32E_WB_ARB_FIXED_PRIO_EN
      last_gnt_d = gnt_idx;
`endif
      if (gnt_rd[4]) begin
        // rd >= 16 does not exist in RV32E: acknowledge, drop, and record it.
        illegal_flag_d = 1'b1;
        if (illegal_cnt_q != {CNT_W{1'b1}}) illegal_cnt_d = illegal_cnt_q + 1'b1;
      end else if (gnt_rd != 5'd0) begin
        rf_wen_d   = 1'b1;
        rf_rd_d    = gnt_rd;
        rf_wdata_d = gnt_data;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rf_wen_q       <= 1'b0;
      rf_rd_q        <= '0;
      rf_wdata_q     <= '0;
      illegal_cnt_q  <= '0;
      illegal_flag_q <= 1'b0;
`ifndef RV32E_WB_ARB_FIXED_PRIO_EN
      last_gnt_q     <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      rf_wen_q       <= rf_wen_d;
      rf_rd_q        <= rf_rd_d;
      rf_wdata_q     <= rf_wdata_d;
      illegal_cnt_q  <= illegal_cnt_d;
      illegal_flag_q <= illegal_flag_d;
`ifndef RV32E_WB_ARB_FIXED_PRIO_EN
      last_gnt_q     <= last_gnt_d;
`endif
    end
  end

  assign rf_wen       = rf_wen_q;
  assign rf_rd        = rf_rd_q;
  assign rf_wdata     = rf_wdata_q;
  assign illegal_cnt  = illegal_cnt_q;
  assign illegal_flag = illegal_flag_q;

endmodule

// File: tb/tb_rv32e_rf_wb_arbiter.sv
// Directed bench for rv32e_rf_wb_arbiter with a behavioural writeback model compared every cycle.
module tb_rv32e_rf_wb_arbiter;
  localparam int N     = 3;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic              CLK = 1'b0;
  logic              nRST;
  logic [N-1:0]      req_valid;
  logic [N*5-1:0]    req_rd;
  logic [N*32-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              rf_wen;
  logic [4:0]        rf_rd;
  logic [31:0]       rf_wdata;
  logic [CNT_W-1:0]  illegal_cnt;
  logic              illegal_flag;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  bit chk_en   = 1'b0;

  rv32e_rf_wb_arbiter #(.NUM_REQ(N), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .req_valid(req_valid), .req_rd(req_rd),
    .req_data(req_data), .req_ready(req_ready), .rf_wen(rf_wen), .rf_rd(rf_rd),
    .rf_wdata(rf_wdata), .illegal_cnt(illegal_cnt), .illegal_flag(illegal_flag)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int          m_ptr   = N - 1;
  logic        m_wen   = 1'b0;
  logic [4:0]  m_rd    = '0;
  logic [31:0] m_wdata = '0;
  int          m_cnt   = 0;
  logic        m_flag  = 1'b0;

  function automatic int model_winner();
    int idx;
    if (nRST !== 1'b1) return -1;
`ifdef RV32E_WB_ARB_FIXED_PRIO_EN
    for (int k = 0; k < N; k++) if (req_valid[k]) return k;
`else
    for (int k = 1; k <= N; k++) begin
      idx = (m_ptr + k) % N;
      if (req_valid[idx]) return idx;
    end
`endif
    return -1;
  endfunction

  always @(posedge CLK) begin
    int w;
    logic [4:0] rd;
    if (nRST !== 1'b1) begin
      m_ptr = N - 1; m_wen = 1'b0; m_rd = '0; m_wdata = '0; m_cnt = 0; m_flag = 1'b0;
    end else begin
      w = model_winner();
      m_wen = 1'b0;
      if (w >= 0) begin
        m_ptr = w;
        rd = req_rd[w*5 +: 5];
        if (rd >= 5'd16) begin
          m_flag = 1'b1;
          m_cnt  = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        end else if (rd != 5'd0) begin
          m_wen = 1'b1; m_rd = rd; m_wdata = req_data[w*32 +: 32];
        end
      end
    end
  end

  always @(negedge CLK) begin
    int w;
    logic [N-1:0] exp_rdy;
    if (chk_en) begin
      w = model_winner();
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      chk("cyc_ready", 64'(req_ready), 64'(exp_rdy));
      chk("cyc_wen", 64'(rf_wen), 64'(m_wen));
      chk("cyc_rd", 64'(rf_rd), 64'(m_rd));
      chk("cyc_wdata", 64'(rf_wdata), 64'(m_wdata));
      chk("cyc_cnt", 64'(illegal_cnt), 64'(m_cnt));
      chk("cyc_flag", 64'(illegal_flag), 64'(m_flag));
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] rd, input logic [31:0] d);
    req_valid[i]        = v;
    req_rd[i*5 +: 5]    = rd;
    req_data[i*32 +: 32] = d;
  endtask

  function automatic int ready_idx();
    for (int i = 0; i < N; i++) if (req_ready[i]) return i;
    return -1;
  endfunction

  int exp_order[6];

  initial begin
`ifdef RV32E_WB_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 0, 1, 2};
`endif
    nRST = 1'b0; req_valid = '0; req_rd = '0; req_data = '0;
    step(); step();
    chk_en = 1'b1;

    // ready is held low during reset even with every requester valid
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 1), 32'h0);
    @(negedge CLK);
    chk("ready_in_reset", 64'(req_ready), 64'h0);
    step(); nRST = 1'b1; req_valid = '0;
    @(negedge CLK);
    chk("rst_wen", 64'(rf_wen), 64'h0);
    chk("rst_rd", 64'(rf_rd), 64'h0);
    chk("rst_wdata", 64'(rf_wdata), 64'h0);
    chk("rst_cnt", 64'(illegal_cnt), 64'h0);
    chk("rst_flag", 64'(illegal_flag), 64'h0);

    // single legal write, one-cycle latency
    step(); set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    @(negedge CLK);
    chk("t1_ready", 64'(req_ready), 64'h1);
    step(); req_valid = '0;
    @(negedge CLK);
    chk("t1_wen", 64'(rf_wen), 64'h1);
    chk("t1_rd", 64'(rf_rd), 64'h5);
    chk("t1_wdata", 64'(rf_wdata), 64'hDEADBEEF);

    // re-reset so requester 0 is first again, then all three valid for six cycles
    step(); nRST = 1'b0;
    step(); nRST = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 1), 32'h1000 + 32'(i));
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      chk("rr_order", 64'(ready_idx()), 64'(exp_order[c]));
      step();
    end
    req_valid = '0;

    // write to x0: acknowledged, no write, not illegal
    step(); set_req(1, 1'b1, 5'd0, 32'h55AA55AA);
    @(negedge CLK);
    chk("x0_ready", 64'(req_ready), 64'h2);
    step(); req_valid = '0;
    @(negedge CLK);
    chk("x0_wen", 64'(rf_wen), 64'h0);
    chk("x0_cnt", 64'(illegal_cnt), 64'h0);

    // rd=16 then rd=31 from requester 2
    step(); set_req(2, 1'b1, 5'd16, 32'h1);
    @(negedge CLK);
    chk("ill16_ready", 64'(req_ready), 64'h4);
    step(); set_req(2, 1'b1, 5'd31, 32'h2);
    @(negedge CLK);
    chk("ill31_ready", 64'(req_ready), 64'h4);
    step(); req_valid = '0;
    @(negedge CLK);
    chk("ill_wen", 64'(rf_wen), 64'h0);
    chk("ill_cnt", 64'(illegal_cnt), 64'h2);
    chk("ill_flag", 64'(illegal_flag), 64'h1);

    // 300 more illegal writes: counter saturates at 255
    step(); set_req(2, 1'b1, 5'd17, 32'h3);
    for (int c = 0; c < 299; c++) step();
    step(); req_valid = '0;
    @(negedge CLK);
    chk("sat_cnt", 64'(illegal_cnt), 64'd255);
    chk("sat_flag", 64'(illegal_flag), 64'h1);
    step(); set_req(2, 1'b1, 5'd20, 32'h4);
    step(); req_valid = '0;
    @(negedge CLK);
    chk("sat_hold", 64'(illegal_cnt), 64'd255);

    // reset asserted in the cycle requester 0 would be granted
    step(); nRST = 1'b0; set_req(0, 1'b1, 5'd7, 32'hCAFEF00D);
    @(negedge CLK);
    chk("midrst_ready", 64'(req_ready), 64'h0);
    step(); nRST = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 1), 32'h2000 + 32'(i));
    @(negedge CLK);
    chk("midrst_wen", 64'(rf_wen), 64'h0);
    chk("midrst_rd", 64'(rf_rd), 64'h0);
    chk("midrst_wdata", 64'(rf_wdata), 64'h0);
    chk("midrst_cnt", 64'(illegal_cnt), 64'h0);
    chk("midrst_first", 64'(req_ready), 64'h1);
    step(); req_valid = '0;
    @(negedge CLK);
    chk("midrst_after_wen", 64'(rf_wen), 64'h1);
    chk("midrst_after_rd", 64'(rf_rd), 64'h1);
    step(); step();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
